// File: rtl/mixcolumns_iter.sv
// mixcolumns_iter: AES MixColumns round stage with a valid/ready interface.
//
// A block is taken into a working register, transformed COLS_PER_CYCLE
// columns per clock (4/COLS_PER_CYCLE cycles), then held on state_out until
// downstream takes it.
//
// Optional build macro MIXCOL_INV_EN: when defined, the inverse datapath is
// built and in_inv=1 selects InvMixColumns for that block. When undefined,
// in_inv is ignored and every block gets the forward transform.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset; discards any in-flight block
//   in_valid   state_in / in_inv are valid
//   in_ready   stage can accept a block (IDLE only)
//   state_in   128-bit state; column c = [32c+31:32c], row r = [32c+8r+7:32c+8r]
//   in_inv     1 = InvMixColumns for this block (MIXCOL_INV_EN builds only)
//   out_valid  state_out holds a result (HOLD)
//   out_ready  downstream accepts the result
//   state_out  transformed state, same byte layout; keeps value after handshake
//   busy       FSM not in IDLE
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds data stable while valid is high and not yet taken;
// ready never depends combinationally on valid (both come from the state
// register), so there is no combinational path from in_valid to in_ready or
// from out_ready to out_valid.

module mixcolumns_iter #(
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int NCYC = 4 / COLS_PER_CYCLE;
    // Column index of the final group; RUN ends on this group, not on wrap.
    localparam logic [1:0] LAST_IDX = 2'((NCYC - 1) * COLS_PER_CYCLE);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [127:0]   work_q;
    logic [127:0]   work_next;
    logic [1:0]     col_idx_q;
    logic           last_group;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
        a0 = c[7:0];
        a1 = c[15:8];
        a2 = c[23:16];
        a3 = c[31:24];
        // 3x is xtime(x) ^ x
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b3, b2, b1, b0};
    endfunction

`ifdef MIXCOL_INV_EN
    logic inv_q;

    // 9/11/13/14 multiples from the 2x/4x/8x xtime chain.
    function automatic logic [7:0] m9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] m11(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] m13(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] m14(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
        a0 = c[7:0];
        a1 = c[15:8];
        a2 = c[23:16];
        a3 = c[31:24];
        b0 = m14(a0) ^ m11(a1) ^ m13(a2) ^ m9(a3);
        b1 = m9(a0)  ^ m14(a1) ^ m11(a2) ^ m13(a3);
        b2 = m13(a0) ^ m9(a1)  ^ m14(a2) ^ m11(a3);
        b3 = m11(a0) ^ m13(a1) ^ m9(a2)  ^ m14(a3);
        return {b3, b2, b1, b0};
    endfunction
`else
    // in_inv is kept on the port for interface stability only.
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
`endif

    // Working register with the current column group replaced.
    always_comb begin
        logic [1:0]  idx;
        logic [31:0] col;
        work_next = work_q;
        idx       = '0;
        col       = '0;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            idx = col_idx_q + 2'(g);
            col = work_q[{idx, 5'b0} +: 32];
`ifdef MIXCOL_INV_EN
            work_next[{idx, 5'b0} +: 32] = inv_q ? inv_col(col) : fwd_col(col);
`else
            work_next[{idx, 5'b0} +: 32] = fwd_col(col);
`endif
        end
    end

    assign last_group = (col_idx_q == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last_group) state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q    <= '0;
            col_idx_q <= '0;
            state_out <= '0;
`ifdef MIXCOL_INV_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            if (state_q == IDLE && in_valid) begin
                work_q    <= state_in;
                col_idx_q <= '0;
`ifdef MIXCOL_INV_EN
                inv_q     <= in_inv;
`endif
            end else if (state_q == RUN) begin
                work_q    <= work_next;
                col_idx_q <= col_idx_q + 2'(COLS_PER_CYCLE);
                if (last_group) state_out <= work_next;
            end
        end
    end

endmodule

// File: tb/tb_mixcolumns_iter.sv
// Testbench for mixcolumns_iter: three instances (1, 2 and 4 columns per
// cycle) share clk/rst and are exercised one at a time. Expected states come
// from constants and a generic GF(2^8) multiply model; they are queued when a
// block is driven and popped when the DUT presents its result.

module tb_mixcolumns_iter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]        in_valid;
    logic [2:0]        in_ready;
    logic [2:0]        in_inv;
    logic [2:0]        out_valid;
    logic [2:0]        out_ready;
    logic [2:0]        busy;
    logic [2:0][127:0] state_in;
    logic [2:0][127:0] state_out;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        localparam int P = (i == 0) ? 1 : (i == 1) ? 2 : 4;
        mixcolumns_iter #(.COLS_PER_CYCLE(P)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[i]),
            .in_ready  (in_ready[i]),
            .state_in  (state_in[i]),
            .in_inv    (in_inv[i]),
            .out_valid (out_valid[i]),
            .out_ready (out_ready[i]),
            .state_out (state_out[i]),
            .busy      (busy[i])
        );
    end

    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_q[$];
    logic [127:0] last_out;

    localparam logic [127:0] VEC_A = {32'h4C31262D, 32'h01010101, 32'h5C220AF2, 32'h455313DB};
    localparam logic [127:0] EXP_A = {32'hF8BD7E4D, 32'h01010101, 32'h9D58DC9F, 32'hBCA14D8E};
    localparam logic [127:0] VEC_B = {32'hC6C6C6C6, 32'hD5D4D4D4, 32'hC6C6C6C6, 32'hD5D4D4D4};
    localparam logic [127:0] EXP_B = {32'hC6C6C6C6, 32'hD6D7D5D5, 32'hC6C6C6C6, 32'hD6D7D5D5};

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0]   coef[4];
        logic [127:0] r;
        logic [7:0]   acc;
        if (inv) begin
            coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
        end else begin
            coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - row + 4) % 4], s[32*c + 8*j +: 8]);
                r[32*c + 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic eff_inv(input logic inv);
`ifdef MIXCOL_INV_EN
        return inv;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int ncyc(input int d);
        return (d == 0) ? 4 : (d == 1) ? 2 : 1;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Offer one block on a DUT in IDLE; returns on the negedge after the
    // accept edge with in_valid dropped and in_inv flipped.
    task automatic send(input int d, input logic [127:0] data, input logic inv,
                        input logic [127:0] expv);
        @(negedge clk);
        chk($sformatf("in_ready_idle_d%0d", d), 128'(in_ready[d]), 128'(1));
        in_valid[d] = 1'b1;
        state_in[d] = data;
        in_inv[d]   = inv;
        exp_q.push_back(expv);
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        state_in[d] = {$urandom, $urandom, $urandom, $urandom};
        in_inv[d]   = ~inv;
    endtask

    // Wait for out_valid, counting edges since the accept edge.
    task automatic wait_out(input int d);
        int lat;
        logic [127:0] expv;
        lat = 0;
        while (!out_valid[d] && lat < 20) begin
            chk($sformatf("in_ready_run_d%0d", d), 128'(in_ready[d]), 128'(0));
            chk($sformatf("busy_run_d%0d", d), 128'(busy[d]), 128'(1));
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency_d%0d", d), 128'(lat), 128'(ncyc(d)));
        chk($sformatf("out_valid_d%0d", d), 128'(out_valid[d]), 128'(1));
        chk($sformatf("in_ready_hold_d%0d", d), 128'(in_ready[d]), 128'(0));
        if (exp_q.size() == 0) begin
            chk($sformatf("scoreboard_empty_d%0d", d), 128'(exp_q.size()), 128'(1));
        end else begin
            expv = exp_q.pop_front();
            chk($sformatf("state_out_d%0d", d), state_out[d], expv);
        end
        last_out = state_out[d];
    endtask

    // Complete the output handshake and check the stage is back in IDLE.
    task automatic release_out(input int d);
        out_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[d] = 1'b0;
        chk($sformatf("out_valid_after_d%0d", d), 128'(out_valid[d]), 128'(0));
        chk($sformatf("in_ready_after_d%0d", d), 128'(in_ready[d]), 128'(1));
        chk($sformatf("state_out_kept_d%0d", d), state_out[d], last_out);
    endtask

    task automatic block(input int d, input logic [127:0] data, input logic inv,
                         input logic [127:0] expv);
        send(d, data, inv, expv);
        wait_out(d);
        release_out(d);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] rv;
        logic         ri;

        rst       = 1'b1;
        in_valid  = '0;
        in_inv    = '0;
        out_ready = '0;
        state_in  = '0;
        last_out  = '0;

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_in_ready_d%0d", d), 128'(in_ready[d]), 128'(1));
            chk($sformatf("rst_out_valid_d%0d", d), 128'(out_valid[d]), 128'(0));
            chk($sformatf("rst_busy_d%0d", d), 128'(busy[d]), 128'(0));
            chk($sformatf("rst_state_out_d%0d", d), state_out[d], 128'(0));
        end
        rst = 1'b0;

        // Known vectors on every column-parallelism.
        for (int d = 0; d < 3; d++) begin
            block(d, VEC_A, 1'b0, EXP_A);
            block(d, VEC_B, 1'b0, EXP_B);
        end

        // Random blocks, random mode; model result.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 2; n++) begin
                rv = {$urandom, $urandom, $urandom, $urandom};
                ri = 1'($urandom_range(0, 1));
                block(d, rv, ri, model(rv, eff_inv(ri)));
            end
        end

`ifdef MIXCOL_INV_EN
        // Inverse restores the original state on each instance.
        for (int d = 0; d < 3; d++) block(d, EXP_A, 1'b1, VEC_A);
`else
        // in_inv has no effect without the inverse datapath.
        for (int d = 0; d < 3; d++) block(d, VEC_A, 1'b1, EXP_A);
`endif

        // Backpressure on the 2-column instance; a second block is offered
        // during HOLD and must only be taken once the stage is back in IDLE.
        send(1, VEC_A, 1'b0, EXP_A);
        wait_out(1);
        for (int k = 0; k < 5; k++) begin
            in_valid[1] = 1'b1;
            state_in[1] = VEC_B;
            in_inv[1]   = 1'b0;
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid[1]), 128'(1));
            chk("bp_state_out", state_out[1], last_out);
            chk("bp_in_ready", 128'(in_ready[1]), 128'(0));
        end
        out_ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[1] = 1'b0;
        chk("bp_out_valid_after", 128'(out_valid[1]), 128'(0));
        chk("bp_in_ready_after", 128'(in_ready[1]), 128'(1));
        chk("bp_state_out_kept", state_out[1], last_out);
        exp_q.push_back(EXP_B);
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        wait_out(1);
        release_out(1);

        // Asynchronous reset in the middle of a 1-column run.
        send(0, VEC_B, 1'b0, EXP_B);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 128'(out_valid[0]), 128'(0));
        chk("mid_rst_state_out", state_out[0], 128'(0));
        chk("mid_rst_in_ready", 128'(in_ready[0]), 128'(1));
        chk("mid_rst_busy", 128'(busy[0]), 128'(0));
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_out_valid", 128'(out_valid[0]), 128'(0));
            chk("post_rst_state_out", state_out[0], 128'(0));
        end

        // Recovery after reset.
        block(0, VEC_A, 1'b0, EXP_A);

        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mixcolumns_iter.md
Name: mixcolumns_iter

Overview:
- Parametrised, handshake-driven AES MixColumns engine for the round datapath. Sits between ShiftRows and AddRoundKey.
- Processes COLS_PER_CYCLE 32-bit columns per clock, so area/latency trades 1/2/4 column multipliers.
- Supports forward MixColumns and, when compiled in, InvMixColumns selected per block.
- Replaces the fixed 4-column, enable-pulsed unit with a valid/ready pipeline stage. All column arithmetic is true GF(2^8), with XOR accumulation.

Parameters:
- COLS_PER_CYCLE, 4, columns transformed per clock; legal 1, 2, 4. Any other value is an elaboration error.
- NCYC, 4/COLS_PER_CYCLE (localparam), processing cycles per block.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  state_in/in_inv valid
- in_ready  out  1  block can accept a state
- state_in  in  128  input state; column c = bits [32c+31:32c], row r byte = bits [32c+8r+7:32c+8r]
- in_inv  in  1  1 = InvMixColumns for this block (see Optional Feature)
- out_valid  out  1  state_out holds a result
- out_ready  in  1  downstream accepts result
- state_out  out  128  transformed state, same byte layout
- busy  out  1  FSM not IDLE

Behaviour:
- Reset (async, any time, including mid-block):
  - FSM to IDLE; in_ready=1, out_valid=0, busy=0, state_out=0.
  - Working register, column counter and mode flag cleared. An in-flight block is discarded.
- FSM states: IDLE, RUN, HOLD.
  - IDLE: in_ready=1. On in_valid&&in_ready: capture state_in into the working register and in_inv into the mode flag, clear col_idx, go to RUN.
  - RUN: in_ready=0. Each edge replaces columns col_idx..col_idx+COLS_PER_CYCLE-1 of the working register with their transformed values, then col_idx += COLS_PER_CYCLE. On the edge processing the last column group, copy the full result to state_out, set out_valid=1 and go to HOLD. No early exit.
  - HOLD: out_valid=1; state_out is stable and in_ready=0. On out_ready, clear out_valid next edge and go to IDLE. state_out keeps its last value after the handshake.
- Latency: the accept edge is t0; out_valid rises at edge t0+NCYC (4 for P=1, 2 for P=2, 1 for P=4). Minimum block interval is NCYC+2 cycles.
- in_valid while not in IDLE is ignored (no capture). in_valid is not required to hold after acceptance.
- Forward column (a0..a3 = rows 0..3):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- Inverse column, rows rotate the same way: b0 = 14a0^11a1^13a2^9a3.
- xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00). Multiples 3/9/11/13/14 are built from xtime chains and XOR. No integer addition anywhere.
- The mode flag is sampled only at accept; in_inv changing during RUN has no effect.
- col_idx is log2(4) bits wide. Wrap from 3 to 0 is never used as a termination condition; termination is on the last group.

Optional Feature:
- Macro MIXCOL_INV_EN.
- Defined: the inverse datapath (9/11/13/14 multipliers) is instantiated and in_inv=1 selects InvMixColumns.
- Undefined: no inverse logic is synthesised; in_inv is ignored and the forward transform is always applied. The port remains for interface stability.

Test Plan:
- P=4, forward: state_in column 0 = 32'h455313DB, columns 1–3 = 32'h5C220AF2, 32'h01010101, 32'h4C31262D, accepted at t0 -> out_valid at t0+1. state_out columns = 32'hBCA14D8E, 32'h9D58DC9F, 32'h01010101, 32'hF8BD7E4D.
- P=1 and P=2, same vector -> identical state_out; out_valid at t0+4 and t0+2 respectively; in_ready=0 throughout RUN/HOLD.
- MIXCOL_INV_EN defined: feed the previous output with in_inv=1 -> original state restored. in_inv toggled mid-RUN -> no change in result.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> state_out stable, out_valid=1, a second in_valid is ignored. out_ready=1 -> IDLE next edge, then the second block is accepted.
- rst pulse asynchronously during RUN (P=1, after 2 columns) -> out_valid=0, state_out=0 and in_ready=1 immediately. No stale result ever appears.
- Column 32'hD5D4D4D4 (rows D4,D4,D4,D5) -> 32'hD6D7D5D5. Column 32'hC6C6C6C6 -> unchanged.
